// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers for the fifo_stream block.
//   ptr_width / cnt_width : pointer and occupancy widths for a given depth
//   ptr_inc               : pointer increment with explicit wrap at depth-1
//   ptr_t / cnt_t         : pointer/count types for the default 11-entry build
package fifo_pkg;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Explicit compare so non-power-of-2 depths wrap correctly.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

    localparam int unsigned DEF_DEPTH = 11;
    localparam int unsigned DEF_PTR_W = ptr_width(DEF_DEPTH);
    localparam int unsigned DEF_CNT_W = cnt_width(DEF_DEPTH);

    typedef logic [DEF_PTR_W-1:0] ptr_t;
    typedef logic [DEF_CNT_W-1:0] cnt_t;

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: DEPTH x WIDTH storage, one synchronous write port, one
// asynchronous read port. Contents are not reset; the owner gates the read
// data while the entry is not valid.
//   clk_i    : clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data (combinational from raddr_i)
module fifo_ram #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DEPTH = 11,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_stream.sv
// fifo_stream: valid/ready stream FIFO with arbitrary depth, occupancy count
// and registered full/empty/almost flags. First-word fall-through: a word
// written in cycle N is presented in cycle N+1.
// Optional packet mode is enabled by defining FIFO_PKT_MODE_EN: a last bit is
// stored per entry and the head is only offered once a complete packet is
// stored (or the FIFO is full, so over-long packets cannot deadlock).
//   clk               : clock, rising edge
//   reset             : asynchronous active-low reset
//   fifo_write_tvalid / fifo_write_tready / fifo_wdata / fifo_wlast : write side
//   fifo_read_tvalid  / fifo_read_tready  / fifo_rdata / fifo_rlast : read side
//   fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty      : flags
//   fifo_count        : occupancy
module fifo_stream
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned DEPTH      = 11,
    parameter int unsigned AF_THRESH  = DEPTH - 2,
    parameter int unsigned AE_THRESH  = 1,
    localparam int unsigned CNT_W     = cnt_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_write_tvalid,
    output logic                  fifo_write_tready,
    input  logic [DATA_WIDTH-1:0] fifo_wdata,
`ifdef FIFO_PKT_MODE_EN
    input  logic                  fifo_wlast,
`endif
    output logic                  fifo_read_tvalid,
    input  logic                  fifo_read_tready,
    output logic [DATA_WIDTH-1:0] fifo_rdata,
`ifdef FIFO_PKT_MODE_EN
    output logic                  fifo_rlast,
`endif
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  fifo_almost_full,
    output logic                  fifo_almost_empty,
    output logic [CNT_W-1:0]      fifo_count
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
`ifdef FIFO_PKT_MODE_EN
    localparam int unsigned MEM_W = DATA_WIDTH + 1;
`else
    localparam int unsigned MEM_W = DATA_WIDTH;
`endif

    typedef logic [PTR_W-1:0] idx_t;
    typedef logic [CNT_W-1:0] occ_t;

    idx_t wr_ptr_q, wr_ptr_d;
    idx_t rd_ptr_q, rd_ptr_d;
    occ_t count_q, count_d;
    logic full_q, full_d;
    logic empty_q, empty_d;
    logic af_q, af_d;
    logic ae_q, ae_d;

    logic             wr_en;
    logic             rd_en;
    logic [MEM_W-1:0] ram_wdata;
    logic [MEM_W-1:0] ram_rdata;

    // Full blocks writes even when a read frees a slot in the same cycle.
    assign wr_en = fifo_write_tvalid && !full_q;
    assign rd_en = fifo_read_tvalid && fifo_read_tready;

`ifdef FIFO_PKT_MODE_EN
    occ_t pkt_cnt_q, pkt_cnt_d;
    logic head_last;

    assign ram_wdata = {fifo_wlast, fifo_wdata};
    assign head_last = ram_rdata[DATA_WIDTH];

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if ((wr_en && fifo_wlast) && !(rd_en && head_last)) begin
            pkt_cnt_d = pkt_cnt_q + occ_t'(1);
        end else if (!(wr_en && fifo_wlast) && (rd_en && head_last)) begin
            pkt_cnt_d = pkt_cnt_q - occ_t'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkt_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    // Full override releases packets longer than the FIFO.
    assign fifo_read_tvalid = !empty_q && ((pkt_cnt_q != '0) || full_q);
    assign fifo_rlast       = fifo_read_tvalid ? head_last : 1'b0;
`else
    assign ram_wdata        = fifo_wdata;
    assign fifo_read_tvalid = !empty_q;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = idx_t'(ptr_inc(32'(wr_ptr_q), DEPTH));
        end
        if (rd_en) begin
            rd_ptr_d = idx_t'(ptr_inc(32'(rd_ptr_q), DEPTH));
        end
        if (wr_en && !rd_en) begin
            count_d = count_q + occ_t'(1);
        end else if (rd_en && !wr_en) begin
            count_d = count_q - occ_t'(1);
        end
        // Flags derive from next count so they line up with fifo_count.
        full_d  = (32'(count_d) == DEPTH);
        empty_d = (count_d == '0);
        af_d    = (32'(count_d) >= AF_THRESH);
        ae_d    = (32'(count_d) <= AE_THRESH);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
        end
    end

    fifo_ram #(
        .WIDTH  (MEM_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (ram_wdata),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    // Storage is not reset, so the head is masked whenever it is not offered.
    assign fifo_rdata        = fifo_read_tvalid ? ram_rdata[DATA_WIDTH-1:0] : '0;
    assign fifo_write_tready = !full_q;
    assign fifo_full         = full_q;
    assign fifo_empty        = empty_q;
    assign fifo_almost_full  = af_q;
    assign fifo_almost_empty = ae_q;
    assign fifo_count        = count_q;

endmodule

// File: tb/tb_fifo_stream.sv
module tb_fifo_stream;

    localparam int unsigned DW    = 128;
    localparam int unsigned DEPTH = 11;
    localparam int unsigned AF    = 9;
    localparam int unsigned AE    = 1;
    localparam int unsigned CW    = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          fifo_write_tvalid = 1'b0;
    logic          fifo_write_tready;
    logic [DW-1:0] fifo_wdata = '0;
    logic          fifo_read_tvalid;
    logic          fifo_read_tready = 1'b0;
    logic [DW-1:0] fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_almost_full;
    logic          fifo_almost_empty;
    logic [CW-1:0] fifo_count;
`ifdef FIFO_PKT_MODE_EN
    logic          fifo_wlast = 1'b0;
    logic          fifo_rlast;
`endif

    fifo_stream #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AF_THRESH  (AF),
        .AE_THRESH  (AE)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .fifo_write_tvalid (fifo_write_tvalid),
        .fifo_write_tready (fifo_write_tready),
        .fifo_wdata        (fifo_wdata),
`ifdef FIFO_PKT_MODE_EN
        .fifo_wlast        (fifo_wlast),
`endif
        .fifo_read_tvalid  (fifo_read_tvalid),
        .fifo_read_tready  (fifo_read_tready),
        .fifo_rdata        (fifo_rdata),
`ifdef FIFO_PKT_MODE_EN
        .fifo_rlast        (fifo_rlast),
`endif
        .fifo_full         (fifo_full),
        .fifo_empty        (fifo_empty),
        .fifo_almost_full  (fifo_almost_full),
        .fifo_almost_empty (fifo_almost_empty),
        .fifo_count        (fifo_count)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of stored words with their last bits.
    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } entry_t;

    entry_t q[$];
    int     n_cmp  = 0;
    int     n_fail = 0;
    logic   acc_w, acc_r;
    int     pushed, popped;

    function automatic int pkts_in(input entry_t qq[$]);
        int n = 0;
        foreach (qq[i]) if (qq[i].last) n++;
        return n;
    endfunction

    function automatic logic exp_tvalid(input entry_t qq[$]);
`ifdef FIFO_PKT_MODE_EN
        return (qq.size() > 0) && ((pkts_in(qq) > 0) || (qq.size() == DEPTH));
`else
        return qq.size() > 0;
`endif
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        int sz = q.size();
        check("count", DW'(fifo_count), DW'(sz));
        check("full", DW'(fifo_full), DW'(sz == DEPTH));
        check("empty", DW'(fifo_empty), DW'(sz == 0));
        check("almost_full", DW'(fifo_almost_full), DW'(sz >= AF));
        check("almost_empty", DW'(fifo_almost_empty), DW'(sz <= AE));
        check("write_tready", DW'(fifo_write_tready), DW'(sz < DEPTH));
        check("read_tvalid", DW'(fifo_read_tvalid), DW'(exp_tvalid(q)));
        if (exp_tvalid(q)) begin
            check("rdata", fifo_rdata, q[0].data);
`ifdef FIFO_PKT_MODE_EN
            check("rlast", DW'(fifo_rlast), DW'(q[0].last));
`endif
        end
    endtask

    // One clock: drive at posedge+1, check at negedge, update model at posedge.
    task automatic step(input logic wv, input logic [DW-1:0] wd, input logic wl, input logic rr);
        fifo_write_tvalid = wv;
        fifo_wdata        = wd;
`ifdef FIFO_PKT_MODE_EN
        fifo_wlast        = wl;
`endif
        fifo_read_tready  = rr;
        @(negedge clk);
        check_state();
        acc_w = wv && (q.size() < DEPTH);
        acc_r = rr && exp_tvalid(q);
        @(posedge clk);
        #1;
        if (acc_r) begin
            void'(q.pop_front());
            popped++;
        end
        if (acc_w) begin
            q.push_back('{data: wd, last: wl});
            pushed++;
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (q.size() > 0 && guard < 200) begin
            // Terminate a trailing open packet so it can leave in packet mode.
            step(pkts_in(q) == 0, DW'(guard), 1'b1, 1'b1);
            guard++;
        end
        check("drained", DW'(q.size()), DW'(0));
    endtask

    task automatic do_reset();
        fifo_write_tvalid = 1'b0;
        fifo_read_tready  = 1'b0;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #4;
        check("rst_empty", DW'(fifo_empty), DW'(1));
        check("rst_almost_empty", DW'(fifo_almost_empty), DW'(1));
        check("rst_count", DW'(fifo_count), DW'(0));
        check("rst_read_tvalid", DW'(fifo_read_tvalid), DW'(0));
        check("rst_full", DW'(fifo_full), DW'(0));
        check("rst_almost_full", DW'(fifo_almost_full), DW'(0));
        check("rst_rdata", fifo_rdata, DW'(0));
        q.delete();
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] a5;
        logic [DW-1:0] rnd;
        int cyc;

        pushed = 0;
        popped = 0;
        @(posedge clk);
        #1;
        do_reset();

        // Latency: word written in cycle N is offered in cycle N+1.
        a5 = {16{8'hA5}};
        step(1'b1, a5, 1'b1, 1'b0);
        #3;
        check("latency_tvalid", DW'(fifo_read_tvalid), DW'(1));
        check("latency_rdata", fifo_rdata, a5);
        drain();

        // Fill: 12 attempts, only 11 accepted.
        for (int i = 0; i < 12; i++) step(1'b1, DW'(32'h100 + i), 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        #3;
        check("fill_count", DW'(fifo_count), DW'(11));
        check("fill_full", DW'(fifo_full), DW'(1));
        check("fill_tready", DW'(fifo_write_tready), DW'(0));

        // Full with read: write refused, count drops to 10.
        step(1'b1, DW'(32'hDEAD), 1'b1, 1'b1);
        #3;
        check("full_rw_count", DW'(fifo_count), DW'(10));
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, DW'(32'hBEEF), 1'b1, 1'b1);
        #3;
        check("simul_count", DW'(fifo_count), DW'(5));
        drain();

        // Mid-transfer reset discards contents asynchronously.
        for (int i = 0; i < 6; i++) step(1'b1, DW'(i), 1'b1, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("async_rst_count", DW'(fifo_count), DW'(0));
        check("async_rst_empty", DW'(fifo_empty), DW'(1));
        do_reset();

        // Random traffic against the model.
        pushed = 0;
        popped = 0;
        cyc = 0;
        while (pushed < 11000 && cyc < 60000) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            step($urandom_range(0, 3) != 0, rnd, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 1);
            cyc++;
        end
        drain();
        check("random_words", DW'(pushed >= 11000), DW'(1));
        check("random_no_loss", DW'(popped), DW'(pushed));

`ifdef FIFO_PKT_MODE_EN
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, DW'(32'h200 + i), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        #3;
        check("pkt_hold_tvalid", DW'(fifo_read_tvalid), DW'(0));
        step(1'b1, DW'(32'h203), 1'b1, 1'b0);
        #3;
        check("pkt_release_tvalid", DW'(fifo_read_tvalid), DW'(1));
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 11; i++) step(1'b1, DW'(32'h300 + i), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        #3;
        check("pkt_full_override", DW'(fifo_read_tvalid), DW'(1));
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
